fetch_sequencer: RTL

Instruction-fetch controller for the PLC-style core. It owns the program counter that addresses the 40-bit instruction ROM, which has a combinational read. Each fetched word is registered into an instruction register with a valid flag. It sequences run, stall, jump, halt and cyclic program scans: wrap to address 0 after the last program word, with a scan-complete pulse.

---
 rtl/fetch_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch controller for the PLC-style core. It owns the program
// counter that addresses a combinational-read instruction ROM. Each fetched
// word is captured in an instruction register with a valid flag. Programs are
// scanned cyclically: after the last program word the pc wraps to 0 and
// scan_done pulses together with the valid flag of that last word.
//
// Optional feature macro: FETCH_SCAN_CNT_EN
//   Adds a 16-bit scan_count output. It counts scan_done pulses, wraps at
//   0xFFFF and is cleared when a run is started.
//
// Ports:
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   start           in   pulse, begin a run at pc 0 (from IDLE or HALT)
//   stall           in   level, freeze fetch
//   jump            in   pulse, redirect fetch to jump_addr
//   jump_addr       in   jump target
//   halt_req        in   pulse, stop execution
//   mem_instruction in   ROM read data for address pc
//   pc              out  ROM address (registered)
//   instr           out  instruction register
//   instr_valid     out  instr holds a fresh instruction this cycle
//   scan_done       out  one-cycle pulse at end of a program scan
//   scan_count      out  completed-scan counter (FETCH_SCAN_CNT_EN only)
//   running         out  state is RUN or STALL
//   fault           out  sticky, jump target was out of range
// ---------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int INSTRUCTION_WIDTH = 40,
   parameter int PC_WIDTH          = 5,
   parameter int PROG_LAST         = 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         stall,
   input  logic                         jump,
   input  logic [PC_WIDTH-1:0]          jump_addr,
   input  logic                         halt_req,
   input  logic [INSTRUCTION_WIDTH-1:0] mem_instruction,
   output logic [PC_WIDTH-1:0]          pc,
   output logic [INSTRUCTION_WIDTH-1:0] instr,
   output logic                         instr_valid,
   output logic                         scan_done,
`ifdef FETCH_SCAN_CNT_EN
   output logic [15:0]                  scan_count,
`endif
   output logic                         running,
   output logic                         fault
);

   localparam logic [PC_WIDTH-1:0] PROG_LAST_PC = PC_WIDTH'(PROG_LAST);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t                         state_q, state_d;
   logic [PC_WIDTH-1:0]            pc_q, pc_d;
   logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
   logic                           instr_valid_q, instr_valid_d;
   logic                           scan_done_q, scan_done_d;
   logic                           running_q, running_d;
   logic                           fault_q, fault_d;
   logic                           start_run;

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = 1'b0;
      scan_done_d   = 1'b0;
      fault_d       = fault_q;
      start_run     = 1'b0;

      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d   = ST_RUN;
               pc_d      = '0;
               fault_d   = 1'b0;
               start_run = 1'b1;
            end
         end

         ST_RUN: begin
            if (halt_req) begin
               state_d = ST_HALT;
            end else if (stall) begin
               state_d = ST_STALL;
            end else if (jump) begin
               if (jump_addr > PROG_LAST_PC) begin
                  // Out-of-range target: stop rather than fetch garbage.
                  state_d = ST_HALT;
                  fault_d = 1'b1;
               end else begin
                  // The word currently on mem_instruction belongs to the
                  // abandoned path, so it is dropped (one bubble).
                  pc_d = jump_addr;
               end
            end else begin
               instr_d       = mem_instruction;
               instr_valid_d = 1'b1;
               if (pc_q == PROG_LAST_PC) begin
                  pc_d        = '0;
                  scan_done_d = 1'b1;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end

         ST_STALL: begin
            // Jumps are deliberately dropped here; the requester re-issues.
            if (halt_req) begin
               state_d = ST_HALT;
            end else if (!stall) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      running_d = (state_d == ST_RUN) || (state_d == ST_STALL);
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         pc_q          <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         scan_done_q   <= 1'b0;
         running_q     <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         scan_done_q   <= scan_done_d;
         running_q     <= running_d;
         fault_q       <= fault_d;
      end
   end

`ifdef FETCH_SCAN_CNT_EN
   // ------------------------------------------------------------------------
   // Completed-scan counter; updates on the same edge that raises scan_done.
   // ------------------------------------------------------------------------
   logic [15:0] scan_count_q, scan_count_d;

   always_comb begin
      scan_count_d = scan_count_q;
      if (start_run) begin
         scan_count_d = '0;
      end else if (scan_done_d) begin
         scan_count_d = scan_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_count_q <= '0;
      end else begin
         scan_count_q <= scan_count_d;
      end
   end

   assign scan_count = scan_count_q;
`else
   // start_run only feeds the scan counter.
   logic unused_start_run;
   assign unused_start_run = start_run;
`endif

   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign scan_done   = scan_done_q;
   assign running     = running_q;
   assign fault       = fault_q;

endmodule
